mbist_march_ctrl: RTL



---
 rtl/mbist_pkg.sv | 45 ++++
 rtl/mbist_march_seq.sv | 94 +++++++++
 rtl/mbist_march_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mbist_pkg.sv
// Shared types and constants for the March C- MBIST controller:
// FSM states, the March element table and pipeline depths.
package mbist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // One March element: sweep direction, one or two ops, and the background values.
  typedef struct packed {
    logic dir_down;
    logic two_op;
    logic first_read;
    logic rd_val;
    logic wr_val;
  } march_elem_t;

  localparam int NUM_ELEM     = 6;
  localparam int DRAIN_CYCLES = 4;
  localparam int RD_LATENCY   = 2;

  function automatic logic march_dir_down(input logic [2:0] idx);
    return (idx == 3'd3) || (idx == 3'd4);
  endfunction

  // M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0)
  function automatic march_elem_t march_elem(input logic [2:0] idx);
    march_elem_t e;
    case (idx)
      3'd0:    e = '{dir_down: 1'b0, two_op: 1'b0, first_read: 1'b0, rd_val: 1'b0, wr_val: 1'b0};
      3'd1:    e = '{dir_down: 1'b0, two_op: 1'b1, first_read: 1'b1, rd_val: 1'b0, wr_val: 1'b1};
      3'd2:    e = '{dir_down: 1'b0, two_op: 1'b1, first_read: 1'b1, rd_val: 1'b1, wr_val: 1'b0};
      3'd3:    e = '{dir_down: 1'b1, two_op: 1'b1, first_read: 1'b1, rd_val: 1'b0, wr_val: 1'b1};
      3'd4:    e = '{dir_down: 1'b1, two_op: 1'b1, first_read: 1'b1, rd_val: 1'b1, wr_val: 1'b0};
      3'd5:    e = '{dir_down: 1'b0, two_op: 1'b0, first_read: 1'b1, rd_val: 1'b0, wr_val: 1'b0};
      default: e = '0;
    endcase
    e.dir_down = march_dir_down(idx);
    return e;
  endfunction

endpackage

// File: rtl/mbist_march_seq.sv
// March C- op generator: walks element, address and r/w phase, presenting
// one op per cycle while active.
module mbist_march_seq
  import mbist_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CAPACITY   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init,
  input  logic                  advance,
  output logic                  valid,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY - 1);

  logic [2:0]            elem_q, elem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  phase_q, phase_d;
  logic                  active_q, active_d;

  march_elem_t cur;
  logic        final_phase;
  logic        end_addr;
  logic        last_elem;
  logic        op_val;

  always_comb begin
    cur         = march_elem(elem_q);
    final_phase = !cur.two_op || phase_q;
    end_addr    = cur.dir_down ? (addr_q == '0) : (addr_q == LAST_ADDR);
    last_elem   = (elem_q == 3'(NUM_ELEM - 1));

    elem_d   = elem_q;
    addr_d   = addr_q;
    phase_d  = phase_q;
    active_d = active_q;

    if (init) begin
      elem_d   = '0;
      addr_d   = '0;
      phase_d  = 1'b0;
      active_d = 1'b1;
    end else if (advance && active_q) begin
      if (!final_phase) begin
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        // The end address moves on to the next element instead of wrapping.
        if (end_addr) begin
          if (last_elem) begin
            active_d = 1'b0;
          end else begin
            elem_d = elem_q + 3'd1;
            addr_d = march_dir_down(elem_q + 3'd1) ? LAST_ADDR : '0;
          end
        end else if (cur.dir_down) begin
          addr_d = addr_q - ADDR_WIDTH'(1);
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
    end

    we     = cur.two_op ? phase_q : !cur.first_read;
    op_val = we ? cur.wr_val : cur.rd_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_q   <= '0;
      addr_q   <= '0;
      phase_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      elem_q   <= elem_d;
      addr_q   <= addr_d;
      phase_q  <= phase_d;
      active_q <= active_d;
    end
  end

  assign valid = active_q;
  assign addr  = addr_q;
  assign data  = {DATA_WIDTH{op_val}};
  assign last  = active_q && last_elem && end_addr && final_phase;

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller: run FSM, issue pipeline aligned to the memory's
// write-data lead and read latency, read compare and result registers.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int PIPE_DEPTH = RD_LATENCY + 1;
  localparam int DRAIN_W    = $clog2(DRAIN_CYCLES);

  typedef struct packed {
    logic                  rd;
    logic [DATA_WIDTH-1:0] exp;
    logic [ADDR_WIDTH-1:0] addr;
  } cmp_t;

  state_t               state_q, state_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic                 s0_valid_q, s0_valid_d;
  logic                 s0_we_q, s0_we_d;
  logic [ADDR_WIDTH-1:0] s0_addr_q, s0_addr_d;
  logic [DATA_WIDTH-1:0] s0_exp_q, s0_exp_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                 s1_we_q, s1_we_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  cmp_t                 pipe_q [PIPE_DEPTH];
  cmp_t                 pipe_d [PIPE_DEPTH];
  logic                 pass_q, pass_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [CNT_WIDTH-1:0] fail_count_q, fail_count_d;

  logic                  seq_valid, seq_we, seq_last;
  logic [ADDR_WIDTH-1:0] seq_addr;
  logic [DATA_WIDTH-1:0] seq_data;
  logic                  start_accept;
  logic                  issue;
  logic                  mismatch;

  mbist_march_seq #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .CAPACITY  (CAPACITY)
  ) u_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (start_accept),
    .advance(state_q == RUN),
    .valid  (seq_valid),
    .we     (seq_we),
    .addr   (seq_addr),
    .data   (seq_data),
    .last   (seq_last)
  );

  always_comb begin
    start_accept = start && ((state_q == IDLE) || (state_q == DONE));
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_accept) state_d = RUN;
      end
      RUN: begin
        if (seq_last) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1)) state_d = DONE;
        else drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // S0 holds op i and its write data; S1 presents the op a cycle later so the data leads.
  always_comb begin
    issue      = (state_q == RUN) && seq_valid;
    s0_valid_d = issue;
    s0_we_d    = issue && seq_we;
    s0_addr_d  = issue ? seq_addr : '0;
    s0_exp_d   = issue ? seq_data : '0;
    wdata_d    = (issue && seq_we) ? seq_data : '0;

    s1_we_d    = s0_valid_q && s0_we_q;
    s1_addr_d  = s0_valid_q ? s0_addr_q : '0;

    pipe_d[0].rd   = s0_valid_q && !s0_we_q;
    pipe_d[0].exp  = s0_exp_q;
    pipe_d[0].addr = s0_addr_q;
    for (int k = 1; k < PIPE_DEPTH; k++) pipe_d[k] = pipe_q[k-1];
  end

  // The tap lines up with the read data returned for the op that entered the pipe.
  always_comb begin
    mismatch     = busy && pipe_q[PIPE_DEPTH-1].rd && (mem_rdata != pipe_q[PIPE_DEPTH-1].exp);
    pass_d       = pass_q;
    fail_addr_d  = fail_addr_q;
    fail_count_d = fail_count_q;

    if (start_accept) begin
      pass_d       = 1'b1;
      fail_addr_d  = '0;
      fail_count_d = '0;
    end else if (mismatch) begin
      pass_d = 1'b0;
      if (pass_q) fail_addr_d = pipe_q[PIPE_DEPTH-1].addr;
      if (!(&fail_count_q)) fail_count_d = fail_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      drain_cnt_q  <= '0;
      s0_valid_q   <= 1'b0;
      s0_we_q      <= 1'b0;
      s0_addr_q    <= '0;
      s0_exp_q     <= '0;
      wdata_q      <= '0;
      s1_we_q      <= 1'b0;
      s1_addr_q    <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) pipe_q[k] <= '0;
      pass_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_count_q <= '0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      s0_valid_q   <= s0_valid_d;
      s0_we_q      <= s0_we_d;
      s0_addr_q    <= s0_addr_d;
      s0_exp_q     <= s0_exp_d;
      wdata_q      <= wdata_d;
      s1_we_q      <= s1_we_d;
      s1_addr_q    <= s1_addr_d;
      for (int k = 0; k < PIPE_DEPTH; k++) pipe_q[k] <= pipe_d[k];
      pass_q       <= pass_d;
      fail_addr_q  <= fail_addr_d;
      fail_count_q <= fail_count_d;
    end
  end

  assign busy           = (state_q == RUN) || (state_q == DRAIN);
  assign done           = (state_q == DONE);
  assign pass           = pass_q;
  assign fail_addr      = fail_addr_q;
  assign fail_count     = fail_count_q;
  assign mem_write_read = s1_we_q;
  assign mem_address    = s1_addr_q;
  assign mem_wdata      = wdata_q;

endmodule
